uart_rx_core: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver in the UART path. It adds configurable bit period and data width, optional parity, an input synchroniser, mid-bit sampling with false-start rejection, and framing, parity and overrun detection. Received words are presented through a one-entry valid/ready holding register to the downstream consumer (command decoder / FIFO).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_core_if.sv | 27 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_core.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and default sizing.
// Intended for reuse by both the receiver and the planned parametrised transmitter.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DEFAULT_DATA_BITS    = 8;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_rx_core_if.sv
// Consumer-side bundle of the UART receiver: valid/ready holding register plus status.
// The master modport is the receiver, the slave modport is the downstream consumer.
interface uart_rx_core_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 data_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  data_ready,
    output out_data, data_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    output data_ready,
    input  out_data, data_valid, frame_err, parity_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: clocked state uses non-blocking assignments so both flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with mid-bit sampling, error flags and a one-entry output register.
// Optional parity is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_ODD   = PARITY_MODE_EVEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           udata,
  uart_rx_core_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_START = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_start_tick;
  logic                 w_stop_smp;
  logic                 w_xfer;
  logic                 w_load;
  logic                 w_drop;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (udata),
    .o_q (w_rx_s)
  );

  assign w_tick       = (r_cnt == CNT_LAST);
  assign w_start_tick = (r_cnt == CNT_START);
  assign w_stop_smp   = (r_state == ST_STOP) && w_tick;
  assign w_xfer       = r_valid && rx_if.data_ready;
  // A completed frame may load into a full register only when that word leaves on the same edge.
  assign w_load       = w_stop_smp && (!r_valid || rx_if.data_ready);
  assign w_drop       = w_stop_smp && !w_load;

`ifdef UART_RX_PARITY_EN
  logic r_perr_pend;
  logic r_perr;
`endif

  // NOTE: asynchronous reset is in the sensitivity list, so a mid-frame reset acts without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_perr_pend <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_cnt <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (w_start_tick) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            r_perr_pend <= ((^r_shift) ^ w_rx_s) != (PARITY_ODD != 0);
            r_state     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) r_state <= w_rx_s ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ferr  <= !w_rx_s;
`ifdef UART_RX_PARITY_EN
        r_perr  <= r_perr_pend;
`endif
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      // A drop on the same edge as a transfer keeps the flag set.
      if (w_drop)      r_ovr <= 1'b1;
      else if (w_xfer) r_ovr <= 1'b0;
    end
  end

  assign rx_if.out_data   = r_data;
  assign rx_if.data_valid = r_valid;
  assign rx_if.frame_err  = r_ferr;
  assign rx_if.overrun    = r_ovr;
  assign rx_if.busy       = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = r_perr;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule
